// File: rtl/ascii_hex_word_parser_if.sv
// Byte-in / word-out bundle for the ASCII hex word parser.
// Both streams use valid/ready: a transfer happens on a rising edge where valid and ready are both 1; the source holds data stable while valid is high.
interface ascii_hex_word_parser_if #(
    parameter int DIGITS = 8
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    logic [7:0]    rx_data;
    logic          rx_vld;
    logic          rx_rdy;
    logic [W-1:0]  word;
    logic [CW-1:0] word_cnt;
    logic          word_vld;
    logic          word_rdy;
    logic          err;
    logic [1:0]    err_code;
    logic [1:0]    fsm_state;

    modport master (
        output rx_data, rx_vld, word_rdy,
        input  rx_rdy, word, word_cnt, word_vld, err, err_code, fsm_state
    );

    modport slave (
        input  rx_data, rx_vld, word_rdy,
        output rx_rdy, word, word_cnt, word_vld, err, err_code, fsm_state
    );
endinterface

// File: rtl/ascii_hex_word_parser.sv
// Assembles hex characters from a byte stream into a binary word, releasing it on
// a CR/LF/space terminator and flagging invalid, overlong and timed-out tokens.
module dc_ascii_hex (
    input  logic [7:0] ascii,
    output logic [3:0] hex,
    output logic       hex_flg
);
    logic is_num;
    logic is_letter;

    // Letters a-f / A-F have low nibble 1..6, so adding 9 yields 10..15.
    always_comb begin
        is_num    = (ascii >= 8'h30) && (ascii <= 8'h39);
        is_letter = ((ascii >= 8'h41) && (ascii <= 8'h46)) ||
                    ((ascii >= 8'h61) && (ascii <= 8'h66));
        hex_flg   = is_num || is_letter;
        hex       = 4'd0;
        if (is_num)
            hex = ascii[3:0];
        else if (is_letter)
            hex = ascii[3:0] + 4'd9;
    end
endmodule

module ascii_hex_word_parser #(
    parameter int DIGITS  = 8,
    parameter int TIMEOUT = 0
) (
    input logic                    clk,
    input logic                    rst,
    ascii_hex_word_parser_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [TW-1:0] IDLE_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DIGITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        OUT     = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  acc, acc_nx, word_nx;
    logic [CW-1:0] cnt, cnt_nx, word_cnt_nx;
    logic [TW-1:0] idle_cnt, idle_nx;
    logic          word_vld_nx, err_nx;
    logic [1:0]    err_code_nx;
    logic [3:0]    hex;
    logic          hex_flg;
    logic          accept;
    logic          is_term;

    dc_ascii_hex u_conv (
        .ascii   (bus.rx_data),
        .hex     (hex),
        .hex_flg (hex_flg)
    );

    assign bus.rx_rdy    = !rst && (state != OUT);
    assign bus.fsm_state = state;
    assign accept        = bus.rx_vld && bus.rx_rdy;
    assign is_term       = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A) ||
                           (bus.rx_data == 8'h20);

    always_comb begin
        state_nx    = state;
        acc_nx      = acc;
        cnt_nx      = cnt;
        idle_nx     = '0;
        word_nx     = bus.word;
        word_cnt_nx = bus.word_cnt;
        word_vld_nx = bus.word_vld;
        err_nx      = 1'b0;
        err_code_nx = bus.err_code;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (hex_flg) begin
                        acc_nx   = W'(hex);
                        cnt_nx   = CW'(1);
                        state_nx = ACCUM;
                    end else if (!is_term) begin
                        err_nx      = 1'b1;
                        err_code_nx = 2'b01;
                        state_nx    = DISCARD;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (hex_flg && (cnt != CNT_MAX)) begin
                        acc_nx = (acc << 4) | W'(hex);
                        cnt_nx = cnt + CW'(1);
                    end else if (is_term) begin
                        word_nx     = acc;
                        word_cnt_nx = cnt;
                        word_vld_nx = 1'b1;
                        state_nx    = OUT;
                    end else begin
                        err_nx      = 1'b1;
                        err_code_nx = hex_flg ? 2'b10 : 2'b01;
                        acc_nx      = '0;
                        cnt_nx      = '0;
                        state_nx    = DISCARD;
                    end
                end else if (TO_EN) begin
                    if (idle_cnt == IDLE_LAST) begin
                        err_nx      = 1'b1;
                        err_code_nx = 2'b11;
                        acc_nx      = '0;
                        cnt_nx      = '0;
                        state_nx    = IDLE;
                    end else begin
                        idle_nx = idle_cnt + TW'(1);
                    end
                end
            end
            OUT: begin
                if (bus.word_rdy) begin
                    word_vld_nx = 1'b0;
                    acc_nx      = '0;
                    cnt_nx      = '0;
                    state_nx    = IDLE;
                end
            end
            DISCARD: begin
                // Timeout here only ends the bad token; the error was already reported.
                if (accept) begin
                    if (is_term)
                        state_nx = IDLE;
                end else if (TO_EN) begin
                    if (idle_cnt == IDLE_LAST)
                        state_nx = IDLE;
                    else
                        idle_nx = idle_cnt + TW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            idle_cnt     <= '0;
            bus.word     <= '0;
            bus.word_cnt <= '0;
            bus.word_vld <= 1'b0;
            bus.err      <= 1'b0;
            bus.err_code <= 2'b00;
        end else begin
            state        <= state_nx;
            acc          <= acc_nx;
            cnt          <= cnt_nx;
            idle_cnt     <= idle_nx;
            bus.word     <= word_nx;
            bus.word_cnt <= word_cnt_nx;
            bus.word_vld <= word_vld_nx;
            bus.err      <= err_nx;
            bus.err_code <= err_code_nx;
        end
    end
endmodule

// File: tb/tb_ascii_hex_word_parser.sv
// Bench for ascii_hex_word_parser: directed token sequences followed by random
// byte traffic, checked each cycle against a token-level reference model.
module tb_ascii_hex_word_parser;
    localparam int DIGITS  = 8;
    localparam int TIMEOUT = 4;
    localparam int W       = 4 * DIGITS;
    localparam int CW      = $clog2(DIGITS + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ascii_hex_word_parser_if #(.DIGITS(DIGITS)) bus ();

    ascii_hex_word_parser #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int wrdy_mode = 1;  // 0 never ready, 1 always ready, 2 random

    // Reference model: digits of the current token, discard flag, idle run length
    logic [3:0]    tok_q[$];
    logic [W-1:0]  exp_q[$];
    bit            discarding;
    int            idle_run;
    bit            pending;
    logic [W-1:0]  exp_word;
    logic [CW-1:0] exp_cnt;
    bit            exp_err;
    logic [1:0]    exp_code;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        tok_q.delete();
        exp_q.delete();
        discarding = 1'b0;
        idle_run   = 0;
        pending    = 1'b0;
        exp_word   = '0;
        exp_cnt    = '0;
        exp_err    = 1'b0;
        exp_code   = 2'b00;
    endfunction

    function automatic void classify(input logic [7:0] c, output bit is_dig,
                                     output logic [3:0] v, output bit is_term);
        string digs;
        logic [7:0] lc;
        digs = "0123456789abcdef";
        lc = c;
        if (c >= 8'h41 && c <= 8'h5A) lc = c + 8'd32;
        is_dig = 1'b0;
        v = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (digs[i] == lc) begin
                is_dig = 1'b1;
                v = 4'(i);
            end
        end
        is_term = (c == 8'h0D) || (c == 8'h0A) || (c == 8'h20);
    endfunction

    function automatic void model_step(input bit accepted, input logic [7:0] data, input bit wrdy);
        bit is_dig, is_term;
        logic [3:0] dv;
        longint unsigned value;
        exp_err = 1'b0;
        if (pending) begin
            if (wrdy) pending = 1'b0;
        end else if (accepted) begin
            idle_run = 0;
            classify(data, is_dig, dv, is_term);
            if (discarding) begin
                if (is_term) discarding = 1'b0;
            end else if (is_dig) begin
                if (tok_q.size() == DIGITS) begin
                    exp_err = 1'b1; exp_code = 2'b10;
                    tok_q.delete();
                    discarding = 1'b1;
                end else begin
                    tok_q.push_back(dv);
                end
            end else if (is_term) begin
                if (tok_q.size() > 0) begin
                    value = 0;
                    foreach (tok_q[i]) value = value * 16 + longint'(tok_q[i]);
                    exp_word = W'(value);
                    exp_cnt  = CW'(tok_q.size());
                    pending  = 1'b1;
                    exp_q.push_back(W'(value));
                    tok_q.delete();
                end
            end else begin
                exp_err = 1'b1; exp_code = 2'b01;
                tok_q.delete();
                discarding = 1'b1;
            end
        end else if (tok_q.size() > 0 || discarding) begin
            idle_run++;
            if (idle_run == TIMEOUT) begin
                if (tok_q.size() > 0) begin
                    exp_err = 1'b1; exp_code = 2'b11;
                end
                tok_q.delete();
                discarding = 1'b0;
                idle_run = 0;
            end
        end
    endfunction

    function automatic bit wrdy_now();
        if (wrdy_mode == 2) return bit'($urandom_range(0, 1));
        return bit'(wrdy_mode);
    endfunction

    task automatic step(input bit vld, input logic [7:0] data, input bit wrdy, output bit accepted);
        bus.rx_vld   = vld;
        bus.rx_data  = data;
        bus.word_rdy = wrdy;
        #1;
        check("rx_rdy", 64'(bus.rx_rdy), 64'(!pending));
        accepted = vld && !pending;
        if (pending && wrdy && exp_q.size() > 0)
            check("handshake_word", 64'(bus.word), 64'(exp_q.pop_front()));
        @(posedge clk);
        #1;
        model_step(accepted, data, wrdy);
        check("err", 64'(bus.err), 64'(exp_err));
        check("err_code", 64'(bus.err_code), 64'(exp_code));
        check("word_vld", 64'(bus.word_vld), 64'(pending));
        check("word", 64'(bus.word), 64'(exp_word));
        check("word_cnt", 64'(bus.word_cnt), 64'(exp_cnt));
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int tries;
        tries = 0;
        do begin
            step(1'b1, b, wrdy_now(), acc);
            tries++;
        end while (!acc && tries < 64);
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_byte: byte %02h not accepted after %0d cycles", b, tries);
        end
    endtask

    // '^' stands for carriage return inside directed strings
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte((s[i] == 8'h5E) ? 8'h0D : s[i]);
    endtask

    task automatic idle_cycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++)
            step(1'b0, 8'($urandom_range(0, 255)), wrdy_now(), acc);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.rx_vld   = 1'($urandom_range(0, 1));
        bus.rx_data  = 8'h31;
        bus.word_rdy = 1'b0;
        #1;
        check("rst_rx_rdy", 64'(bus.rx_rdy), 64'd0);
        @(posedge clk);
        #1;
        model_clear();
        check("rst_rx_rdy_after", 64'(bus.rx_rdy), 64'd0);
        check("rst_word", 64'(bus.word), 64'd0);
        check("rst_word_cnt", 64'(bus.word_cnt), 64'd0);
        check("rst_word_vld", 64'(bus.word_vld), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_err_code", 64'(bus.err_code), 64'd0);
        rst        = 1'b0;
        bus.rx_vld = 1'b0;
    endtask

    initial begin
        string hexchars;
        int r;
        hexchars     = "0123456789abcdefABCDEF";
        bus.rx_vld   = 1'b0;
        bus.rx_data  = 8'h00;
        bus.word_rdy = 1'b0;
        model_clear();

        do_reset();

        wrdy_mode = 1;
        send_str("1a2B^");
        idle_cycles(2);

        wrdy_mode = 0;
        send_str("DEADBEEF ");
        idle_cycles(5);
        wrdy_mode = 1;
        idle_cycles(2);

        send_str("12G4\n5\n");
        idle_cycles(2);

        send_str("123456789^");
        send_str("^^7^");
        idle_cycles(2);

        send_str("aA ");
        idle_cycles(1);

        send_str("AB");
        idle_cycles(4);
        send_str("AB");
        idle_cycles(3);
        send_str("C^");
        idle_cycles(2);

        send_str("!?");
        idle_cycles(5);

        send_str("FF");
        do_reset();
        send_str("3^");
        idle_cycles(2);

        wrdy_mode = 0;
        send_str("77^");
        idle_cycles(1);
        do_reset();
        wrdy_mode = 1;
        send_str("9\n");
        idle_cycles(2);

        wrdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)
                send_byte(hexchars[$urandom_range(0, 21)]);
            else if (r < 62)
                send_byte(8'h0D);
            else if (r < 68)
                send_byte(8'h0A);
            else if (r < 72)
                send_byte(8'h20);
            else if (r < 80)
                send_byte(8'($urandom_range(0, 255)));
            else
                idle_cycles($urandom_range(1, 6));
        end
        wrdy_mode = 1;
        idle_cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
